// File: rtl/ahb_slave_mem_pkg.sv
// Shared AHB-Lite codes, FSM state type and byte-lane helpers for the memory slave.
package ahb_slave_mem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: lane_strobe = 4'b0001 << lo;
      HSIZE_HALF: lane_strobe = lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_strobe = 4'b1111;
      default:    lane_strobe = 4'b0000;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_HALF: is_aligned = ~lo[0];
      HSIZE_WORD: is_aligned = (lo == 2'b00);
      default:    is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_bytewr.sv
// Word-wide storage with per-byte write enables and an asynchronous read port.
module ahb_sram_bytewr #(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: address-phase capture, wait-state FSM, legality check and
// byte-lane write strobes in front of a byte-writable word memory.
module ahb_slave_mem
  import ahb_slave_mem_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 256,
  parameter int WAIT_STATES    = 1
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rst_in,
  input  logic                      ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic                      ahb_write_in,
  input  logic [2:0]                ahb_size_in,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
  input  logic                      ahb_ready_in,
  output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
  output logic                      ahb_readyout_out,
  output logic                      ahb_resp_out
);

  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [AHB_ADDR_WIDTH-1:0] BYTE_SPACE = AHB_ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [IW-1:0] idx_q;
  logic [1:0]    lo_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic          ready_q;
  logic          resp_q;

  logic          can_accept;
  logic          accept;
  logic          legal;
  logic [3:0]    byte_we;
  logic [31:0]   mem_rdata;

  // WAIT and ERR1 hold HREADY low, so only the ready states may take a new address phase.
  assign can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept = can_accept && ahb_sel_in && ahb_ready_in &&
                  (ahb_trans_in != HTRANS_IDLE) && (ahb_trans_in != HTRANS_BUSY);

  assign legal = (ahb_size_in <= HSIZE_WORD) &&
                 is_aligned(ahb_size_in, ahb_addr_in[1:0]) &&
                 (ahb_addr_in < BYTE_SPACE);

  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b1;
      resp_q   <= HRESP_OKAY;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      lo_q     <= 2'b00;
      size_q   <= 3'd0;
      write_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= ahb_addr_in[IW+1:2];
      lo_q    <= ahb_addr_in[1:0];
      size_q  <= ahb_size_in;
      write_q <= ahb_write_in;
      if (!legal) begin
        state   <= ST_ERR1;
        ready_q <= 1'b0;
        resp_q  <= HRESP_ERROR;
      end else if (WAIT_STATES == 0) begin
        state   <= ST_DATA;
        ready_q <= 1'b1;
        resp_q  <= HRESP_OKAY;
      end else begin
        state    <= ST_WAIT;
        ready_q  <= 1'b0;
        resp_q   <= HRESP_OKAY;
        wait_cnt <= WS_INIT;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state   <= ST_DATA;
            ready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= HRESP_ERROR;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Writes land only on the DATA edge, so an aborted or errored transfer never touches memory.
  assign byte_we = (state == ST_DATA && write_q) ? lane_strobe(size_q, lo_q) : 4'b0000;

  ahb_sram_bytewr #(
    .DEPTH (MEM_DEPTH),
    .IW    (IW)
  ) u_sram (
    .clk   (ahb_clk_in),
    .we    (byte_we),
    .addr  (idx_q),
    .wdata (ahb_wdata_in[31:0]),
    .rdata (mem_rdata)
  );

  assign ahb_rdata_out    = (state == ST_DATA && !write_q) ? AHB_DATA_WIDTH'(mem_rdata) : '0;
  assign ahb_readyout_out = ready_q;
  assign ahb_resp_out     = resp_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed and random checks of two slave instances (zero and one wait state) against a byte-level memory model.
module tb_ahb_slave_mem;
  import ahb_slave_mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       sel, wr;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][1:0]  trans;
  logic [1:0][2:0]  size;

  logic        ro0, ro1, rs0, rs1;
  logic [31:0] rd0, rd1;

  int total = 0;
  int bad = 0;

  logic [7:0] mb [2][1024];

  ahb_slave_mem #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel[0]), .ahb_addr_in(addr[0]),
    .ahb_trans_in(trans[0]), .ahb_write_in(wr[0]), .ahb_size_in(size[0]), .ahb_wdata_in(wdata[0]),
    .ahb_ready_in(ro0), .ahb_rdata_out(rd0), .ahb_readyout_out(ro0), .ahb_resp_out(rs0));

  ahb_slave_mem #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)) dut1 (
    .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel[1]), .ahb_addr_in(addr[1]),
    .ahb_trans_in(trans[1]), .ahb_write_in(wr[1]), .ahb_size_in(size[1]), .ahb_wdata_in(wdata[1]),
    .ahb_ready_in(ro1), .ahb_rdata_out(rd1), .ahb_readyout_out(ro1), .ahb_resp_out(rs1));

  function automatic logic get_ro(input int d);
    return (d == 0) ? ro0 : ro1;
  endfunction
  function automatic logic get_resp(input int d);
    return (d == 0) ? rs0 : rs1;
  endfunction
  function automatic logic [31:0] get_rd(input int d);
    return (d == 0) ? rd0 : rd1;
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int base;
    base = int'(a[9:0]) & ~3;
    return {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input int d, input logic w, input logic [31:0] a, input logic [2:0] sz,
                            input logic [1:0] tr);
    sel[d] = 1'b1; trans[d] = tr; wr[d] = w; addr[d] = a; size[d] = sz;
  endtask

  task automatic bus_idle(input int d);
    sel[d] = 1'b0; trans[d] = HTRANS_IDLE;
  endtask

  // Called just after a rising edge; returns just after the edge that ends the data phase.
  task automatic data_phase(input int d, output int cyc, output logic rf, output logic rl,
                            output logic [31:0] rd, output logic early);
    cyc = 0; rf = 1'b0; rl = 1'b0; rd = 'x; early = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      cyc++;
      if (i == 0) rf = get_resp(d);
      if (get_ro(d)) begin
        rl = get_resp(d);
        rd = get_rd(d);
        break;
      end
      if (get_rd(d) !== 32'h0) early = 1'b1;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // One non-pipelined transfer checked against the model; d doubles as the wait-state count.
  task automatic do_xfer(input int d, input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, output logic [31:0] rd);
    bit   legal;
    int   nb, cyc, ba;
    logic rf, rl, early;
    nb = (sz <= 3'd2) ? (1 << sz) : 1;
    legal = (sz <= 3'd2) && ((int'(a[1:0]) & (nb - 1)) == 0) && (a < 32'd1024);
    addr_phase(d, w, a, sz, HTRANS_NONSEQ);
    @(posedge clk); #1;
    bus_idle(d);
    wdata[d] = wd;
    data_phase(d, cyc, rf, rl, rd, early);
    if (legal) begin
      check("okay_cycles", 32'(cyc), 32'(d + 1));
      check("okay_resp_first", 32'(rf), 32'(0));
      check("okay_resp_last", 32'(rl), 32'(0));
      check("okay_rdata_zero_in_wait", 32'(early), 32'(0));
      if (w) begin
        for (int i = 0; i < nb; i++) begin
          ba = int'(a) + i;
          mb[d][ba] = wd[8*(ba % 4) +: 8];
        end
      end else begin
        check("read_data", rd, model_word(d, a));
      end
    end else begin
      check("err_cycles", 32'(cyc), 32'(2));
      check("err_resp_first", 32'(rf), 32'(1));
      check("err_resp_last", 32'(rl), 32'(1));
      check("err_rdata", rd, 32'h0);
    end
    $display("xfer dut%0d %s addr=%h size=%0d legal=%0d cycles=%0d rdata=%h",
             d, w ? "WR" : "RD", a, sz, legal, cyc, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, wv [4];
    logic [2:0]  sz;
    int          cyc, r;
    logic        rf, rl, early;

    sel = '0; wr = '0; addr = '0; wdata = '0; trans = '0; size = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", 32'(ro0), 32'(1));
    check("rst_resp0", 32'(rs0), 32'(0));
    check("rst_rdata0", rd0, 32'h0);
    check("rst_ready1", 32'(ro1), 32'(1));
    check("rst_resp1", 32'(rs1), 32'(0));
    check("rst_rdata1", rd1, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Give every word a known value so later reads are fully predictable.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++)
        do_xfer(d, 1'b1, 32'(w * 4), HSIZE_WORD, $urandom, rd);

    // Word write then read back.
    do_xfer(1, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, rd);
    do_xfer(1, 1'b0, 32'h10, HSIZE_WORD, $urandom, rd);
    check("word_readback", rd, 32'hDEADBEEF);

    // Byte and halfword lane merging; unused lanes carry random data.
    do_xfer(1, 1'b1, 32'h10, HSIZE_WORD, 32'h11223344, rd);
    do_xfer(1, 1'b1, 32'h13, HSIZE_BYTE, {8'hAA, 24'($urandom)}, rd);
    do_xfer(1, 1'b0, 32'h10, HSIZE_WORD, $urandom, rd);
    check("byte_merge", rd, 32'hAA223344);
    do_xfer(1, 1'b1, 32'h10, HSIZE_HALF, {16'($urandom), 16'hBEEF}, rd);
    do_xfer(1, 1'b0, 32'h10, HSIZE_WORD, $urandom, rd);
    check("half_merge", rd, 32'hAA22BEEF);

    // Out-of-range accesses error and leave memory alone.
    do_xfer(1, 1'b0, 32'h400, HSIZE_WORD, $urandom, rd);
    do_xfer(1, 1'b1, 32'h410, HSIZE_WORD, $urandom, rd);
    do_xfer(1, 1'b0, 32'h10, HSIZE_WORD, $urandom, rd);
    check("oor_unchanged", rd, 32'hAA22BEEF);

    // Misaligned halfword errors; a new transfer accepted during ERR2 completes OKAY.
    for (int d = 0; d < 2; d++) begin
      addr_phase(d, 1'b1, 32'h1, HSIZE_HALF, HTRANS_NONSEQ);
      @(posedge clk); #1;
      bus_idle(d);
      wdata[d] = $urandom;
      @(negedge clk);
      check("err1_ready", 32'(get_ro(d)), 32'(0));
      check("err1_resp", 32'(get_resp(d)), 32'(1));
      @(posedge clk); #1;
      addr_phase(d, 1'b0, 32'h0, HSIZE_WORD, HTRANS_NONSEQ);
      @(negedge clk);
      check("err2_ready", 32'(get_ro(d)), 32'(1));
      check("err2_resp", 32'(get_resp(d)), 32'(1));
      @(posedge clk); #1;
      bus_idle(d);
      data_phase(d, cyc, rf, rl, rd, early);
      check("err2_accept_cycles", 32'(cyc), 32'(d + 1));
      check("err2_accept_resp", 32'(rl), 32'(0));
      check("err2_accept_rdata", rd, model_word(d, 32'h0));
      $display("err2 pipelined accept dut%0d cycles=%0d rdata=%h", d, cyc, rd);
      do_xfer(d, 1'b1, 32'h20, 3'd3, $urandom, rd);
      do_xfer(d, 1'b0, 32'h20, HSIZE_WORD, $urandom, rd);
    end

    // Zero-wait back-to-back: four writes then four reads with no idle cycles.
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        addr_phase(0, k < 4, 32'h80 + 32'(4 * (k % 4)), HSIZE_WORD,
                   (k == 0 || k == 4) ? HTRANS_NONSEQ : HTRANS_SEQ);
        if (k < 4) wv[k] = $urandom;
      end else begin
        bus_idle(0);
      end
      if (k >= 1 && k <= 4) wdata[0] = wv[k-1];
      @(negedge clk);
      check("b2b_ready", 32'(ro0), 32'(1));
      check("b2b_resp", 32'(rs0), 32'(0));
      if (k >= 1 && k <= 4) begin
        for (int i = 0; i < 4; i++) mb[0][32'h80 + 4 * (k - 1) + i] = wv[k-1][8*i +: 8];
      end
      if (k >= 5) check("b2b_read", rd0, model_word(0, 32'h80 + 32'(4 * (k - 5))));
      $display("b2b cycle %0d ready=%0d rdata=%h", k, ro0, rd0);
      @(posedge clk); #1;
    end

    // Reset during the wait cycle of a write aborts it with no memory update.
    addr_phase(1, 1'b1, 32'h20, HSIZE_WORD, HTRANS_NONSEQ);
    @(posedge clk); #1;
    bus_idle(1);
    wdata[1] = ~model_word(1, 32'h20);
    @(negedge clk);
    check("abort_in_wait", 32'(ro1), 32'(0));
    #1 rst = 1'b1;
    #1;
    check("abort_ready", 32'(ro1), 32'(1));
    check("abort_resp", 32'(rs1), 32'(0));
    check("abort_rdata", rd1, 32'h0);
    $display("reset mid-write ready=%0d resp=%0d rdata=%h", ro1, rs1, rd1);
    @(posedge clk); #1;
    rst = 1'b0;
    do_xfer(1, 1'b0, 32'h20, HSIZE_WORD, $urandom, rd);

    // Random mix including illegal sizes, misalignment and out-of-range addresses.
    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < 2; d++) begin
        r  = $urandom_range(0, 15);
        sz = (r == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a  = 32'($urandom_range(0, 1023));
        if (r != 2 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
        if (r == 1) a = a + 32'h400 * 32'($urandom_range(1, 8));
        do_xfer(d, 1'($urandom), a, sz, $urandom, rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
